// File: rtl/ddr_rd_chk_pkg.sv
// Shared types and the address-derived read-data pattern for ddr_rd_checker.
package ddr_rd_chk_pkg;

  typedef enum logic {IDLE, RUN} state_t;

  localparam int LANES  = 8;
  localparam int LANE_W = 32;
  localparam int PAT_AW = 25;
  localparam int PAT_DW = LANES * LANE_W;

  // Lane i carries {i, 3'b000, addr} so a swapped lane or wrong address both show up.
  function automatic logic [PAT_DW-1:0] exp_word(input logic [PAT_AW-1:0] addr);
    logic [PAT_DW-1:0] w;
    w = '0;
    for (int i = 0; i < LANES; i++)
      w[i*LANE_W +: LANE_W] = {4'(i), 3'b000, addr};
    return w;
  endfunction

endpackage

// File: rtl/ddr_rd_checker_if.sv
// Read-issue / read-return bus between the MIG user side and ddr_rd_checker.
interface ddr_rd_checker_if #(
  parameter int ADDR_W = 25,
  parameter int DATA_W = 256
);
  logic              issue_valid;
  logic [ADDR_W-1:0] issue_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_data_valid;
  logic              fifo_full;

  modport master (output issue_valid, issue_addr, rd_data, rd_data_valid, input fifo_full);
  modport slave  (input issue_valid, issue_addr, rd_data, rd_data_valid, output fifo_full);
endinterface

// File: rtl/ddr_rd_chk_fifo.sv
// In-order outstanding-address FIFO; full/empty are registered, read data is the head entry.
module ddr_rd_chk_fifo #(
  parameter int AW    = 25,
  parameter int DEPTH = 32
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] din,
  output logic [AW-1:0] dout,
  output logic          full,
  output logic          empty
);
  localparam int PW = $clog2(DEPTH);

  logic [AW-1:0] mem [DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [PW:0]   cnt, cnt_nxt;

  assign dout = mem[rptr];

  always_comb begin
    cnt_nxt = cnt;
    case ({push, pop})
      2'b10:   cnt_nxt = cnt + (PW+1)'(1);
      2'b01:   cnt_nxt = cnt - (PW+1)'(1);
      default: cnt_nxt = cnt;
    endcase
  end

  always_ff @(posedge clk)
    if (push) mem[wptr] <= din;

  always_ff @(posedge clk) begin
    if (clr) begin
      wptr  <= '0;
      rptr  <= '0;
      cnt   <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      cnt   <= cnt_nxt;
      full  <= (cnt_nxt == (PW+1)'(DEPTH));
      empty <= (cnt_nxt == '0);
    end
  end

endmodule

// File: rtl/ddr_rd_checker.sv
// Read-data checker: pairs each returned word with its issued address and counts matches.
// Optional DDR_RD_CHK_LANE_EN adds sticky per-lane mismatch flags (err_lanes).
module ddr_rd_checker
  import ddr_rd_chk_pkg::*;
#(
  parameter int ADDR_W     = 25,
  parameter int DATA_W     = 256,
  parameter int FIFO_DEPTH = 32,
  parameter int CNT_W      = 32
) (
  input  logic              ui_clk,
  input  logic              ui_clk_sync_rst,
  input  logic              start,
  input  logic              stop,
  ddr_rd_checker_if.slave   bus,
  output logic              running,
  output logic [CNT_W-1:0]  ok_count,
  output logic [CNT_W-1:0]  err_count,
  output logic              first_err_valid,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic              overflow,
  output logic              underflow
`ifdef DDR_RD_CHK_LANE_EN
  , output logic [LANES-1:0] err_lanes
`endif
);
  state_t            state;
  logic              act, clr, push, pop, full, empty;
  logic [ADDR_W-1:0] head_addr;
  logic              vld_s0;
  logic [ADDR_W-1:0] s0_addr;
  logic [DATA_W-1:0] s0_data;
  logic [PAT_DW-1:0] exp_w;
  logic [LANES-1:0]  lane_err;
  logic              mism;

  // A start cycle only clears; traffic on that same cycle is dropped.
  assign act  = (state == RUN) && !start;
  assign clr  = ui_clk_sync_rst || start;
  assign push = act && bus.issue_valid && !full;
  assign pop  = act && bus.rd_data_valid && !empty;
  assign bus.fifo_full = full;

  ddr_rd_chk_fifo #(.AW(ADDR_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (ui_clk),
    .clr   (clr),
    .push  (push),
    .pop   (pop),
    .din   (bus.issue_addr),
    .dout  (head_addr),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge ui_clk) begin
    if (ui_clk_sync_rst) begin
      state   <= IDLE;
      running <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin state <= RUN; running <= 1'b1; end
        RUN:  if (!start && stop) begin state <= IDLE; running <= 1'b0; end
        default: begin state <= IDLE; running <= 1'b0; end
      endcase
    end
  end

  // Stage 0: capture popped address with its data
  always_ff @(posedge ui_clk) begin
    if (clr) vld_s0 <= 1'b0;
    else     vld_s0 <= pop;
    if (pop) begin
      s0_addr <= head_addr;
      s0_data <= bus.rd_data;
    end
  end

  always_comb begin
    exp_w    = exp_word(PAT_AW'(s0_addr));
    lane_err = '0;
    for (int i = 0; i < LANES; i++)
      lane_err[i] = (s0_data[i*LANE_W +: LANE_W] != exp_w[i*LANE_W +: LANE_W]);
    mism = |lane_err;
  end

  // Stage 1: counters and sticky status; a stop does not squash an in-flight compare
  always_ff @(posedge ui_clk) begin
    if (clr) begin
      ok_count        <= '0;
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_addr  <= '0;
      overflow        <= 1'b0;
      underflow       <= 1'b0;
    end else begin
      if (act && bus.issue_valid && full)    overflow  <= 1'b1;
      if (act && bus.rd_data_valid && empty) underflow <= 1'b1;
      if (vld_s0) begin
        if (mism) begin
          if (err_count != '1) err_count <= err_count + CNT_W'(1);
          if (!first_err_valid) begin
            first_err_valid <= 1'b1;
            first_err_addr  <= s0_addr;
          end
        end else if (ok_count != '1) begin
          ok_count <= ok_count + CNT_W'(1);
        end
      end
    end
  end

`ifdef DDR_RD_CHK_LANE_EN
  always_ff @(posedge ui_clk) begin
    if (clr)         err_lanes <= '0;
    else if (vld_s0) err_lanes <= err_lanes | lane_err;
  end
`endif

endmodule

// File: tb/tb_ddr_rd_checker.sv
// Directed bench for ddr_rd_checker with an address-queue scoreboard and a latency-1 result model.
module tb_ddr_rd_checker;
  localparam int AW = 25, DW = 256, DEPTH = 32, CW = 32;

  logic ui_clk = 1'b0, rst = 1'b1, start = 1'b0, stop = 1'b0;
  always #5 ui_clk = ~ui_clk;

  ddr_rd_checker_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  logic          running, fev, ovf, unf;
  logic [CW-1:0] ok_c, err_c;
  logic [AW-1:0] fea;
`ifdef DDR_RD_CHK_LANE_EN
  logic [7:0]    err_lanes;
`endif

  ddr_rd_checker #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .ui_clk          (ui_clk),
    .ui_clk_sync_rst (rst),
    .start           (start),
    .stop            (stop),
    .bus             (bus),
    .running         (running),
    .ok_count        (ok_c),
    .err_count       (err_c),
    .first_err_valid (fev),
    .first_err_addr  (fea),
    .overflow        (ovf),
    .underflow       (unf)
`ifdef DDR_RD_CHK_LANE_EN
    , .err_lanes     (err_lanes)
`endif
  );

  // scoreboard / model state
  logic [AW-1:0] m_q[$];
  logic [CW-1:0] m_ok, m_err;
  logic [AW-1:0] m_fea, p_a;
  logic [7:0]    m_lanes, p_l;
  bit            m_run, m_fev, m_ovf, m_unf, pv;
  int            checks = 0, errors = 0;
  logic [DW-1:0] flip;

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    logic [DW-1:0] w;
    for (int i = 0; i < 8; i++) w[32*i +: 32] = {4'(i), 3'b000, a};
    return w;
  endfunction

  function automatic logic [7:0] bad_lanes(input logic [DW-1:0] d, input logic [AW-1:0] a);
    logic [DW-1:0] e;
    logic [7:0]    b;
    e = pat(a);
    for (int i = 0; i < 8; i++) b[i] = (d[32*i +: 32] != e[32*i +: 32]);
    return b;
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("running",   DW'(running), DW'(m_run));
    chk("fifo_full", DW'(bus.fifo_full), DW'(m_q.size() == DEPTH));
    chk("ok_count",  DW'(ok_c),  DW'(m_ok));
    chk("err_count", DW'(err_c), DW'(m_err));
    chk("first_err_valid", DW'(fev), DW'(m_fev));
    chk("first_err_addr",  DW'(fea), DW'(m_fea));
    chk("overflow",  DW'(ovf), DW'(m_ovf));
    chk("underflow", DW'(unf), DW'(m_unf));
`ifdef DDR_RD_CHK_LANE_EN
    chk("err_lanes", DW'(err_lanes), DW'(m_lanes));
`endif
  endtask

  task automatic model_clear();
    m_q.delete();
    m_ok = '0; m_err = '0; m_fea = '0; m_lanes = '0;
    m_fev = 0; m_ovf = 0; m_unf = 0; pv = 0;
  endtask

  task automatic do_rst();
    rst = 1; start = 0; stop = 0;
    bus.issue_valid = 0; bus.rd_data_valid = 0;
    @(posedge ui_clk);
    model_clear();
    m_run = 0;
    #1;
    check_all();
    rst = 0;
  endtask

  task automatic step(input bit st, input bit sp, input bit iv, input logic [AW-1:0] ia,
                      input bit dv, input logic [DW-1:0] dd);
    bit full_pre;
    logic [AW-1:0] a;
    start = st; stop = sp;
    bus.issue_valid = iv; bus.issue_addr = ia;
    bus.rd_data_valid = dv; bus.rd_data = dd;
    @(posedge ui_clk);
    // result of last cycle's pop lands now unless start discards it
    if (pv && !st) begin
      if (p_l == 8'h00) begin
        if (m_ok != '1) m_ok++;
      end else begin
        if (m_err != '1) m_err++;
        if (!m_fev) begin m_fev = 1; m_fea = p_a; end
        m_lanes |= p_l;
      end
    end
    pv = 0;
    if (st) begin
      model_clear();
      m_run = 1;
    end else if (m_run) begin
      full_pre = (m_q.size() == DEPTH);
      if (dv) begin
        if (m_q.size() == 0) m_unf = 1;
        else begin
          a = m_q.pop_front();
          pv = 1; p_a = a; p_l = bad_lanes(dd, a);
        end
      end
      if (iv) begin
        if (full_pre) m_ovf = 1;
        else m_q.push_back(ia);
      end
      if (sp) m_run = 0;
    end
    #1;
    check_all();
  endtask

  task automatic idle(); step(0, 0, 0, '0, 0, '0); endtask
  task automatic issue(input logic [AW-1:0] a); step(0, 0, 1, a, 0, '0); endtask
  task automatic ret(input logic [DW-1:0] x); step(0, 0, 0, '0, 1, pat(m_q[0]) ^ x); endtask

  initial begin
    bus.issue_valid = 0; bus.issue_addr = '0; bus.rd_data_valid = 0; bus.rd_data = '0;
    m_run = 0; model_clear();
    do_rst(); do_rst();

    // IDLE ignores traffic
    step(0, 0, 1, 25'd7, 1, '0);
    idle();

    // ten clean reads
    step(1, 0, 0, '0, 0, '0);
    for (int i = 0; i < 10; i++) issue(AW'(i));
    for (int i = 0; i < 10; i++) ret('0);
    idle(); idle();
    chk("ok10", DW'(ok_c), DW'(10));

    // lane 5 bit 0 flipped on addr 2, then a later error must not overwrite first_err
    step(1, 0, 0, '0, 0, '0);
    for (int i = 0; i < 4; i++) issue(AW'(i));
    flip = '0; flip[160] = 1'b1;
    ret('0); ret('0); ret(flip); ret('0);
    idle();
    chk("err_addr2", DW'(fea), DW'(2));
    chk("err1_ok3", DW'({ok_c, err_c}), DW'({32'd3, 32'd1}));
    issue(25'd9);
    flip = '0; flip[3] = 1'b1;
    ret(flip);
    idle();
    chk("err_addr_kept", DW'(fea), DW'(2));

    // fill to full, overflow on the 33rd, drain 32
    step(1, 0, 0, '0, 0, '0);
    for (int i = 0; i < 33; i++) issue(AW'(100 + i));
    chk("full_after_fill", DW'(bus.fifo_full), DW'(1));
    for (int i = 0; i < 32; i++) ret('0);
    idle(); idle();
    chk("ok32", DW'(ok_c), DW'(32));

    // issue+return while full: push dropped, pop still happens
    step(1, 0, 0, '0, 0, '0);
    for (int i = 0; i < 32; i++) issue(AW'(200 + i));
    step(0, 0, 1, 25'd999, 1, pat(m_q[0]));
    idle();
    chk("full_cleared", DW'(bus.fifo_full), DW'(0));

    // underflow
    step(1, 0, 0, '0, 0, '0);
    step(0, 0, 0, '0, 1, pat(25'd5));
    idle();

    // start+stop together keeps RUN; stop; start from IDLE; sustained stream
    step(1, 1, 0, '0, 0, '0);
    step(0, 1, 0, '0, 0, '0);
    step(1, 0, 0, '0, 0, '0);
    for (int k = 0; k < 100; k++) begin
      if (m_q.size() >= 4) step(0, 0, 1, AW'(k), 1, pat(m_q[0]));
      else                 step(0, 0, 1, AW'(k), 0, '0);
    end
    while (m_q.size() > 0) ret('0);
    idle();
    chk("ok100", DW'(ok_c), DW'(100));

    // start mid-stream clears everything next cycle
    for (int k = 0; k < 20; k++) begin
      if (m_q.size() >= 4) step(k == 10, 0, 1, AW'(k), 1, pat(m_q[0]));
      else                 step(k == 10, 0, 1, AW'(k), 0, '0);
    end
    while (m_q.size() > 0) ret('0);
    idle();

    // compare in flight at stop completes
    step(1, 0, 0, '0, 0, '0);
    issue(25'h1abcdef);
    step(0, 1, 0, '0, 1, pat(m_q[0]));
    idle();
    chk("stop_inflight", DW'(ok_c), DW'(1));

    // reset with outstanding reads, then IDLE valids ignored
    step(1, 0, 0, '0, 0, '0);
    for (int i = 0; i < 5; i++) issue(AW'(50 + i));
    step(0, 0, 0, '0, 1, pat(m_q[0]));
    do_rst();
    step(0, 0, 0, '0, 1, pat(25'd51));
    idle();
    chk("post_rst_ok", DW'(ok_c), DW'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ddr_rd_checker.md
Name: ddr_rd_checker

Overview:
- Read-data checker sitting directly downstream of ddr_ram_control_mig in the ui_clk domain.
- Records every accepted read address in an in-order address FIFO.
- On each rd_data_valid, pops the oldest address, compares rd_data against the address-derived pattern, and counts matches/mismatches.
- Provides hardware pass/fail status for board read tests instead of manual ILA inspection.

Parameters:
- ADDR_W, 25, width of the controller read address.
- DATA_W, 256, width of rd_data; must equal 8*32.
- FIFO_DEPTH, 32, outstanding-address FIFO entries; power of two, ≥2.
- CNT_W, 32, width of ok/err counters.

Ports:
- ui_clk  input  1  controller user-interface clock
- ui_clk_sync_rst  input  1  synchronous, active-high reset
- start  input  1  pulse: clear counters/flags/FIFO, enter RUN
- stop  input  1  pulse: return to IDLE, counters frozen
- issue_valid  input  1  read accepted by controller this cycle (rd_en && !rd_busy)
- issue_addr  input  ADDR_W  address of that read
- rd_data  input  DATA_W  controller read data
- rd_data_valid  input  1  rd_data valid qualifier
- fifo_full  output  1  FIFO full; upstream must stop issuing
- running  output  1  state == RUN
- ok_count  output  CNT_W  matching words
- err_count  output  CNT_W  mismatching words
- first_err_valid  output  1  sticky: a mismatch has been seen
- first_err_addr  output  ADDR_W  address of first mismatch
- overflow  output  1  sticky: issue while full (address dropped)
- underflow  output  1  sticky: rd_data_valid with FIFO empty

Behaviour:
- Reset:
  - state=IDLE; FIFO empty.
  - All counters 0; all sticky flags 0; first_err_addr 0.
  - fifo_full 0; running 0.
- States:
  - IDLE: start -> RUN. issue/rd_data_valid ignored (no push, no pop, no counting).
  - RUN: stop -> IDLE. start in RUN re-clears everything and stays in RUN. start and stop in the same cycle: start wins.
- Clearing: start clears counters, flags and FIFO in the cycle it is sampled; issue/valid in that same cycle are ignored.
- Expected pattern for address A: 32-bit lane i (i=0..7, lane 0 = rd_data[31:0]) = {4'(i), 3'b000, A[24:0]}.
- FIFO behaviour (RUN only):
  - Push on issue_valid when not full.
  - Pop on rd_data_valid when not empty.
  - Simultaneous push and pop is allowed; occupancy is unchanged.
  - Pop sees only entries present before this cycle; there is no same-cycle bypass.
  - Pointers wrap modulo FIFO_DEPTH; occupancy counter is $clog2(FIFO_DEPTH)+1 bits.
- fifo_full is registered and asserted when occupancy == FIFO_DEPTH.
  - Issue while full: address dropped, overflow set, push suppressed; a same-cycle pop still occurs.
- rd_data_valid with FIFO empty: underflow set; no count change; no pop.
- Compare pipeline:
  - Stage 0: popped address and rd_data are registered.
  - Stage 1: 256-bit compare. Counters and first_err update exactly 1 cycle after the rd_data_valid cycle (latency 1), sustaining one compare per cycle.
- Mismatch: err_count++. If first_err_valid==0, latch the address into first_err_addr and set first_err_valid. Later errors do not overwrite it.
- Match: ok_count++.
- Counters saturate at all-ones; no wrap.
- A compare in flight when stop arrives still completes; a compare in flight when start arrives is discarded.
- Reset mid-operation: all state returns to reset values on the next edge; pipeline contents are discarded.

Optional Feature:
- Macro: DDR_RD_CHK_LANE_EN
- Defined: adds output err_lanes[7:0], sticky, bit i set when lane i mismatches on any compare. Cleared by reset and start.
- Undefined: port absent; no lane logic.

Decomposition:
- Package ddr_rd_chk_pkg holds:
  - typedef state_t {IDLE, RUN}
  - LANES=8, LANE_W=32
  - function exp_word(addr) returning the DATA_W pattern.
- One sub-module, ddr_rd_chk_fifo: synchronous FIFO with push/pop/full/empty and ADDR_W/FIFO_DEPTH parameters.

Test Plan:
- start; issue addrs 0..9; return the correct pattern for each, one per cycle -> ok_count=10, err_count=0, no flags, each count update lands 1 cycle after its valid.
- Issue 0..3; return a word for addr 2 with lane 5 bit 0 flipped -> ok_count=3, err_count=1, first_err_addr=2, first_err_valid=1; with DDR_RD_CHK_LANE_EN, err_lanes=8'h20.
- Issue 33 addresses with no returns (FIFO_DEPTH=32) -> fifo_full=1 after 32 pushes, overflow=1, the 33rd address is never checked; then return 32 correct words -> ok_count=32.
- rd_data_valid with no outstanding issue -> underflow=1, ok_count=err_count=0.
- Sustained 100 cycles of simultaneous issue and return, with data returning 4 cycles behind issue; include start pulses in IDLE and in RUN -> ok_count=100; a start mid-stream clears all counters and flags to 0 on the next cycle.
- Assert ui_clk_sync_rst while 5 reads are outstanding -> all outputs 0 next cycle; subsequent valids in IDLE are ignored.
